// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake: the fetch stage is the master, imem the slave.
// One request is outstanding at a time; ack marks the cycle rdata is valid.
interface fetch_stage_if;
  logic        req;
  logic [63:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request,
// one-entry hold buffer and the IF/ID pipeline register.
// FETCH: request outstanding. HOLD: instruction buffered, no request.
// DRAIN: redirected while a request was in flight; its response is dropped.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pc_load,
  input  logic          if_id_load,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [63:0]   if_id_pc,
  output logic [31:0]   if_id_instr,
  output logic          if_id_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [31:0] hold_instr;
  logic        fetch_ack;
  logic        have_instr;
  logic        advance;
  logic [31:0] instr;
  logic        req;
  logic        unused_bits;

  // Redirect targets are word aligned; the low bits are dropped.
  assign unused_bits = ^redirect_pc[1:0];

  // A response counts as an instruction only in FETCH; DRAIN acks are stale.
  assign fetch_ack  = (state == FETCH) && imem.ack;
  assign have_instr = fetch_ack || (state == HOLD);
  assign instr      = (state == HOLD) ? hold_instr : imem.rdata;
  assign advance    = if_id_load && pc_load && have_instr;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state logic in the same priority order as the datapath below.
  always_comb begin
    // NOTE: default first so every path assigns state_next; no latch.
    state_next = state;
    if (redirect_valid) begin
      state_next = (state != HOLD && !imem.ack) ? DRAIN : FETCH;
    end else if (state == DRAIN) begin
      if (imem.ack) state_next = FETCH;
    end else if (advance) begin
      state_next = FETCH;
    end else if (fetch_ack) begin
      state_next = HOLD;
    end
  end

  // Outputs: request whenever a fetch is pending and not in reset.
  always_comb begin
    req = ((state == FETCH) || (state == DRAIN)) && !reset;
  end

  assign imem.req  = req;
  assign imem.addr = pc;

  // PC and IF/ID register: redirect flushes, a stall freezes, otherwise
  // either the fetched instruction or a bubble enters IF/ID.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_pc    <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[63:2], 2'b00};
      if_id_pc    <= pc;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (if_id_load) begin
      if (advance) begin
        if_id_pc    <= pc;
        if_id_instr <= instr;
        if_id_valid <= 1'b1;
        pc          <= pc + 64'd4;
      end else begin
        if_id_pc    <= pc;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end

  // Hold buffer: park a response that cannot enter IF/ID this cycle.
  always_ff @(posedge clock) begin
    // NOTE: data only; its validity is the HOLD state, so it needs no reset.
    if (fetch_ack && !advance) hold_instr <= imem.rdata;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed timing scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic        T       = 1'b1;
  localparam logic        F       = 1'b0;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_load;
  logic        if_id_load;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [63:0] w_pc;
  logic [31:0] w_instr;
  logic        w_valid;

  int total = 0;
  int bad   = 0;

  // Memory model state.
  bit          busy;
  int          cnt;
  int          lat_lo;
  int          lat_hi;
  logic [63:0] lat_addr;
  logic        last_req;
  logic [63:0] last_start_addr;

  always #5 clock = ~clock;

  // Address-derived instruction pattern; never equal to NOP for test addresses.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  fetch_stage_if imem();
  fetch_stage_if imem2();

  fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .pc_load        (pc_load),
    .if_id_load     (if_id_load),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
  );

  // Second instance exercising PC wraparound with a zero-wait memory.
  fetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clock          (clock),
    .reset          (reset),
    .pc_load        (1'b1),
    .if_id_load     (1'b1),
    .redirect_valid (1'b0),
    .redirect_pc    (64'h0),
    .imem           (imem2),
    .if_id_pc       (w_pc),
    .if_id_instr    (w_instr),
    .if_id_valid    (w_valid)
  );

  assign imem2.ack   = imem2.req;
  assign imem2.rdata = mem_word(imem2.addr);

  // One clock cycle: drive inputs after the falling edge, let the memory
  // model answer the request, then return 1 time unit after the rising edge.
  task automatic step(input logic r, input logic pl, input logic il,
                      input logic rv, input logic [63:0] rpc);
    @(negedge clock);
    reset          = r;
    pc_load        = pl;
    if_id_load     = il;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    last_req   = imem.req;
    imem.ack   = 1'b0;
    imem.rdata = 32'hDEAD_DEAD;
    if (r) begin
      busy = 1'b0;
    end else if (imem.req) begin
      if (!busy) begin
        busy            = 1'b1;
        lat_addr        = imem.addr;
        last_start_addr = imem.addr;
        cnt             = int'($urandom_range(lat_hi, lat_lo));
      end
      if (cnt == 0) begin
        imem.ack   = 1'b1;
        imem.rdata = mem_word(lat_addr);
        busy       = 1'b0;
      end else begin
        cnt--;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    lat_lo = 0; lat_hi = 0;
    step(T, T, T, F, 64'h0);
    step(T, T, T, F, 64'h0);
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h0, NOP, 1'b0}) begin
      bad++; $display("FAIL reset_if_id: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {64'h0, NOP, 1'b0});
    end
    total++;
    if (imem.addr !== 64'h0) begin
      bad++; $display("FAIL reset_addr: got %h want %h", imem.addr, 64'h0);
    end
    total++;
    if (last_req !== 1'b0) begin
      bad++; $display("FAIL reset_req: got %b want 0", last_req);
    end
  endtask

  task automatic test_zero_wait();
    logic [63:0] e;
    lat_lo = 0; lat_hi = 0;
    for (int k = 0; k < 4; k++) begin
      step(F, T, T, F, 64'h0);
      if (k == 0) begin
        total++;
        if (last_req !== 1'b1) begin
          bad++; $display("FAIL req_after_reset: got %b want 1", last_req);
        end
      end
      e = 64'(4 * k);
      total++;
      if ({if_id_pc, if_id_instr, if_id_valid} !== {e, mem_word(e), 1'b1}) begin
        bad++; $display("FAIL zero_wait[%0d]: got %h want %h", k, {if_id_pc, if_id_instr, if_id_valid}, {e, mem_word(e), 1'b1});
      end
    end
  endtask

  task automatic test_stall_hold();
    logic [96:0] snap;
    logic [63:0] p;
    lat_lo = 0; lat_hi = 0;
    snap = {if_id_pc, if_id_instr, if_id_valid};
    p    = imem.addr;
    for (int k = 0; k < 3; k++) begin
      step(F, T, F, F, 64'h0);
      total++;
      if ({if_id_pc, if_id_instr, if_id_valid} !== snap) begin
        bad++; $display("FAIL stall_frozen[%0d]: got %h want %h", k, {if_id_pc, if_id_instr, if_id_valid}, snap);
      end
      total++;
      if (last_req !== (k == 0)) begin
        bad++; $display("FAIL stall_req[%0d]: got %b want %b", k, last_req, (k == 0));
      end
    end
    step(F, T, T, F, 64'h0);
    total++;
    if (last_req !== 1'b0) begin
      bad++; $display("FAIL release_refetch: got req %b want 0", last_req);
    end
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {p, mem_word(p), 1'b1}) begin
      bad++; $display("FAIL release_entry: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {p, mem_word(p), 1'b1});
    end
  endtask

  task automatic test_pc_stall();
    lat_lo = 0; lat_hi = 0;
    for (int k = 0; k < 3; k++) step(F, T, T, F, 64'h0);
    total++;
    if (imem.addr !== 64'h20) begin
      bad++; $display("FAIL advance_to_20: got %h want %h", imem.addr, 64'h20);
    end
    for (int k = 0; k < 2; k++) begin
      step(F, F, T, F, 64'h0);
      total++;
      if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h20, NOP, 1'b0}) begin
        bad++; $display("FAIL pc_stall_bubble[%0d]: got %h want %h", k, {if_id_pc, if_id_instr, if_id_valid}, {64'h20, NOP, 1'b0});
      end
    end
    step(F, T, T, F, 64'h0);
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h20, mem_word(64'h20), 1'b1}) begin
      bad++; $display("FAIL pc_stall_release: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {64'h20, mem_word(64'h20), 1'b1});
    end
  endtask

  task automatic test_drain();
    logic [63:0] p;
    bit          found;
    int          n;
    lat_lo = 3; lat_hi = 3;
    step(F, T, T, F, 64'h0);
    p = imem.addr;
    step(F, T, T, T, 64'h103);
    total++;
    if (imem.addr !== 64'h100) begin
      bad++; $display("FAIL drain_addr: got %h want %h", imem.addr, 64'h100);
    end
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {p, NOP, 1'b0}) begin
      bad++; $display("FAIL drain_flush: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {p, NOP, 1'b0});
    end
    found = 1'b0;
    n     = 0;
    while (!found && n < 16) begin
      step(F, T, T, F, 64'h0);
      n++;
      if (if_id_valid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL drain_timeout: got no valid entry in %0d cycles want one", n);
    end
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h100, mem_word(64'h100), 1'b1}) begin
      bad++; $display("FAIL drain_entry: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {64'h100, mem_word(64'h100), 1'b1});
    end
    total++;
    if (n !== 6) begin
      bad++; $display("FAIL drain_latency: got %0d cycles want 6", n);
    end
    total++;
    if (last_start_addr !== 64'h100) begin
      bad++; $display("FAIL drain_new_req: got %h want %h", last_start_addr, 64'h100);
    end
  endtask

  task automatic test_redirect_ack_stall();
    logic [63:0] p;
    lat_lo = 0; lat_hi = 0;
    p = imem.addr;
    step(F, T, F, T, 64'h200);
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {p, NOP, 1'b0}) begin
      bad++; $display("FAIL redir_stall_flush: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {p, NOP, 1'b0});
    end
    total++;
    if (imem.addr !== 64'h200) begin
      bad++; $display("FAIL redir_stall_addr: got %h want %h", imem.addr, 64'h200);
    end
    step(F, T, T, F, 64'h0);
    total++;
    if ({last_req, last_start_addr} !== {1'b1, 64'h200}) begin
      bad++; $display("FAIL redir_stall_req: got %h want %h", {last_req, last_start_addr}, {1'b1, 64'h200});
    end
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h200, mem_word(64'h200), 1'b1}) begin
      bad++; $display("FAIL redir_stall_entry: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {64'h200, mem_word(64'h200), 1'b1});
    end
  endtask

  task automatic test_reset_mid_request();
    lat_lo = 3; lat_hi = 3;
    step(F, T, T, F, 64'h0);
    step(T, T, T, F, 64'h0);
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid, imem.addr} !== {64'h0, NOP, 1'b0, 64'h0}) begin
      bad++; $display("FAIL mid_reset: got %h want %h", {if_id_pc, if_id_instr, if_id_valid, imem.addr}, {64'h0, NOP, 1'b0, 64'h0});
    end
    lat_lo = 0; lat_hi = 0;
    step(F, T, T, F, 64'h0);
    total++;
    if ({if_id_pc, if_id_instr, if_id_valid} !== {64'h0, mem_word(64'h0), 1'b1}) begin
      bad++; $display("FAIL mid_reset_refetch: got %h want %h", {if_id_pc, if_id_instr, if_id_valid}, {64'h0, mem_word(64'h0), 1'b1});
    end
  endtask

  task automatic test_pc_wrap();
    lat_lo = 0; lat_hi = 0;
    step(T, T, T, F, 64'h0);
    total++;
    if ({w_pc, w_instr, w_valid, imem2.addr} !== {WRAP_PC, NOP, 1'b0, WRAP_PC}) begin
      bad++; $display("FAIL wrap_reset: got %h want %h", {w_pc, w_instr, w_valid, imem2.addr}, {WRAP_PC, NOP, 1'b0, WRAP_PC});
    end
    step(F, T, T, F, 64'h0);
    total++;
    if ({w_pc, w_instr, w_valid} !== {WRAP_PC, mem_word(WRAP_PC), 1'b1}) begin
      bad++; $display("FAIL wrap_first: got %h want %h", {w_pc, w_instr, w_valid}, {WRAP_PC, mem_word(WRAP_PC), 1'b1});
    end
    step(F, T, T, F, 64'h0);
    total++;
    if ({w_pc, w_instr, w_valid} !== {64'h0, mem_word(64'h0), 1'b1}) begin
      bad++; $display("FAIL wrap_second: got %h want %h", {w_pc, w_instr, w_valid}, {64'h0, mem_word(64'h0), 1'b1});
    end
  endtask

  // Stream model: IF/ID must carry the program-order instruction stream
  // (next address exp_pc, +4 per delivery, jump on redirect) or bubbles.
  task automatic test_random_stream();
    logic [63:0] exp_pc;
    logic [63:0] rpc;
    logic [96:0] snap;
    logic [96:0] want;
    logic        pl, il, rv;
    int          delivered;
    delivered = 0;
    lat_lo = 0; lat_hi = 0;
    step(T, T, T, F, 64'h0);
    exp_pc = 64'h0;
    lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      pl   = ($urandom_range(3, 0) != 0);
      il   = ($urandom_range(3, 0) != 0);
      rv   = ($urandom_range(15, 0) == 0);
      rpc  = {$urandom, $urandom};
      snap = {if_id_pc, if_id_instr, if_id_valid};
      step(F, pl, il, rv, rpc);
      if (rv) begin
        want   = {exp_pc, NOP, 1'b0};
        exp_pc = {rpc[63:2], 2'b00};
      end else if (!il) begin
        want = snap;
      end else if (if_id_valid === 1'b1) begin
        want = {exp_pc, mem_word(exp_pc), 1'b1};
        total++;
        if (pl !== 1'b1) begin
          bad++; $display("FAIL stream_pc_load[%0d]: got delivery with pc_load %b want 1", i, pl);
        end
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end else begin
        want = {exp_pc, NOP, 1'b0};
      end
      total++;
      if ({if_id_pc, if_id_instr, if_id_valid} !== want) begin
        bad++; $display("FAIL stream_if_id[%0d]: got %h want %h", i, {if_id_pc, if_id_instr, if_id_valid}, want);
      end
      total++;
      if (imem.addr !== exp_pc) begin
        bad++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem.addr, exp_pc);
      end
    end
    total++;
    if (delivered < 200) begin
      bad++; $display("FAIL stream_progress: got %0d deliveries want >= 200", delivered);
    end
  endtask

  initial begin
    reset          = 1'b1;
    pc_load        = 1'b0;
    if_id_load     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem.ack       = 1'b0;
    imem.rdata     = 32'h0;
    busy           = 1'b0;
    cnt            = 0;
    lat_lo         = 0;
    lat_hi         = 0;
    lat_addr       = 64'h0;
    last_req       = 1'b0;
    last_start_addr = 64'h0;

    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_pc_stall();
    test_drain();
    test_redirect_ack_stall();
    test_reset_mid_request();
    test_pc_wrap();
    test_random_stream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
